// File: rtl/sparse_unpack_if.sv
// Handshake bundle for sparse_unpack: mask and value input channels plus
// the dense output channel. master is the surrounding logic, slave the decoder.
interface sparse_unpack_if #(
  parameter int col = 8,
  parameter int bw  = 4
);
  logic [col-1:0]    mask_in;
  logic              mask_valid;
  logic              mask_ready;
  logic [bw-1:0]     val_in;
  logic              val_valid;
  logic              val_ready;
  logic [bw*col-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mask_in, mask_valid, val_in, val_valid, out_ready,
    input  mask_ready, val_ready, out_data, out_valid
  );

  modport slave (
    input  mask_in, mask_valid, val_in, val_valid, out_ready,
    output mask_ready, val_ready, out_data, out_valid
  );
endinterface

// File: rtl/sparse_unpack.sv
// Rebuilds dense bw*col weight vectors from a lane mask plus surviving values.
// Define SPARSE_ERR_EN to build the sticky zero-value protocol error flag.
module sparse_unpack #(
  parameter int col = 8,
  parameter int bw  = 4
) (
  input  logic             clk,
  input  logic             reset,
  sparse_unpack_if.slave   bus,
  output logic [15:0]      vec_cnt,
  output logic             err
);

  localparam int lw = (col > 1) ? $clog2(col) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]        state;
  logic [col-1:0]    rem;
  logic [col-1:0]    rem_next;
  logic [bw*col-1:0] data;
  logic [15:0]       cnt_q;
  logic [lw-1:0]     lane;
  logic              mask_xfer;
  logic              val_xfer;
  logic              out_xfer;

  assign bus.mask_ready = (state == IDLE);
  assign bus.val_ready  = (state == FILL);
  assign bus.out_valid  = (state == OUT);
  assign bus.out_data   = data;
  assign vec_cnt        = cnt_q;

  assign mask_xfer = bus.mask_valid && bus.mask_ready;
  assign val_xfer  = bus.val_valid  && bus.val_ready;
  assign out_xfer  = bus.out_valid  && bus.out_ready;

  // Values arrive in ascending lane order, so the target is the lowest
  // lane still pending; clearing that bit is rem & (rem - 1).
  always_comb begin
    lane = '0;
    for (int i = col - 1; i >= 0; i--) begin
      if (rem[i]) lane = lw'(i);
    end
  end

  assign rem_next = rem & (rem - col'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      data  <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mask_xfer) begin
            rem   <= bus.mask_in;
            data  <= '0;
            state <= (bus.mask_in == '0) ? OUT : FILL;
          end
        end
        FILL: begin
          if (val_xfer) begin
            data[lane*bw +: bw] <= bus.val_in;
            rem <= rem_next;
            if (rem_next == '0) state <= OUT;
          end
        end
        OUT: begin
          if (out_xfer) begin
            cnt_q <= cnt_q + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPARSE_ERR_EN
  // A surviving value of zero contradicts its mask bit; it is still stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (val_xfer && (bus.val_in == '0)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
